// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory block-read responder.
// Holds the FSM state encoding and the block/word geometry used by the top level.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } imem_state_t;

    localparam int BLOCK_BYTES     = 16;
    localparam int WORD_BITS       = 32;
    localparam int BLOCK_BITS      = 128;
    localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;

endpackage

// File: rtl/imem_latency_counter.sv
// Loadable down-counter used to time memory accesses.
// The 'zero' flag marks the last wait cycle. A load takes priority over a decrement.
// The counter saturates at zero.
module imem_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // Count register: cleared by reset, reloaded per request, then counted down to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory: block-read responder for the instruction cache miss path.
// A request is accepted in IDLE. The FSM then waits READ_LATENCY edges in WAIT.
// It returns one 128-bit block for a single RESP cycle.
// Optional build macro IMEM_PROG_EN adds a word-wide programming port.
// The programming port accepts writes only while the memory is idle and unrequested.
module instruction_memory
    import imem_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 28,
    parameter int    NUM_BLOCKS   = 256,
    parameter int    READ_LATENCY = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst_read,
    input  logic [ADDR_WIDTH-1:0] inst_address,
    output logic [BLOCK_BITS-1:0] inst_readdata,
    output logic                  inst_busywait
`ifdef IMEM_PROG_EN
    ,
    input  logic                  prog_we,
    input  logic [31:0]           prog_addr,
    input  logic [31:0]           prog_wdata,
    output logic                  prog_busy
`endif
);

    localparam int IDX_W     = $clog2(NUM_BLOCKS);
    localparam int WOFF_W    = $clog2(WORDS_PER_BLOCK);
    localparam int WIDX_W    = IDX_W + WOFF_W;
    localparam int NUM_WORDS = NUM_BLOCKS * WORDS_PER_BLOCK;
    localparam int CNT_W     = $clog2(READ_LATENCY + 1);

    // Word-organised storage; storage is never cleared by reset.
    logic [WORD_BITS-1:0] mem_words [NUM_WORDS];

    imem_state_t            state_reg;
    imem_state_t            state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [BLOCK_BITS-1:0]  readdata_reg;
    logic [BLOCK_BITS-1:0]  block_rd;
    logic                   addr_oor;
    logic                   capture;
    logic                   data_load;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;

    imem_latency_counter #(
        .WIDTH(CNT_W)
    ) u_latency_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CNT_W'(READ_LATENCY - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Any latched address bit above the storage index selects an empty (all-zero) block.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_oor
            assign addr_oor = |addr_reg[ADDR_WIDTH-1:IDX_W];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    // Gather the four words of the latched block; word k lands at bits [32k+31:32k].
    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
            assign block_rd[gi*WORD_BITS +: WORD_BITS] =
                mem_words[{addr_reg[IDX_W-1:0], WOFF_W'(gi)}];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    // busywait is combinational in IDLE, so the cache sees busy in its very first request cycle.
    always_comb begin
        state_next    = state_reg;
        inst_busywait = 1'b0;
        capture       = 1'b0;
        data_load     = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        case (state_reg)
            IDLE: begin
                inst_busywait = inst_read;
                if (inst_read) begin
                    capture    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                inst_busywait = 1'b1;
                if (cnt_zero) begin
                    data_load  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request address on acceptance; later address changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_reg <= '0;
        end else if (capture) begin
            addr_reg <= inst_address;
        end
    end

    // Registered block read; the output changes only on the WAIT->RESP edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readdata_reg <= '0;
        end else if (data_load) begin
            readdata_reg <= addr_oor ? '0 : block_rd;
        end
    end

    assign inst_readdata = readdata_reg;

`ifdef IMEM_PROG_EN
    logic              prog_in_range;
    logic              prog_accept;
    logic [WIDX_W-1:0] prog_widx;
    logic              prog_addr_unused;

    // Writes are refused whenever a fetch is in flight or being requested.
    assign prog_busy        = (state_reg != IDLE) || inst_read;
    assign prog_widx        = prog_addr[WIDX_W+1:2];
    assign prog_in_range    = ~|prog_addr[31:WIDX_W+2];
    assign prog_accept      = prog_we && !prog_busy && prog_in_range;
    assign prog_addr_unused = ^prog_addr[1:0];

    // Word write port into the program storage.
    always_ff @(posedge clock) begin
        if (prog_accept) begin
            mem_words[prog_widx] <= prog_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory.
// Covers reset, fetch latency, address hold, back-to-back fetches, reset in WAIT,
// range boundaries, and the programming port when IMEM_PROG_EN is defined.
module tb_instruction_memory;
    import imem_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         inst_read = 1'b0;
    logic [27:0]  inst_address = '0;
    logic [127:0] inst_readdata;
    logic         inst_busywait;
`ifdef IMEM_PROG_EN
    logic         prog_we = 1'b0;
    logic [31:0]  prog_addr = '0;
    logic [31:0]  prog_wdata = '0;
    logic         prog_busy;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] B0   = {32'h0F0F0F0F, 32'h0E0E0E0E, 32'h0D0D0D0D, 32'hFFFF0000};
    localparam logic [127:0] B2   = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};
    localparam logic [127:0] B2_P = {32'h0D0E0F10, 32'h090A0B0C, 32'hDEADBEEF, 32'h01020304};
    localparam logic [127:0] B3   = {32'h0000006F, 32'h00108133, 32'h00A00093, 32'h00000013};
    localparam logic [127:0] B5   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] B7   = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    localparam logic [127:0] B255 = {32'h89ABCDEF, 32'h01234567, 32'h5A5A5A5A, 32'hA5A5A5A5};

    always #5 clock = ~clock;

    instruction_memory #(
        .ADDR_WIDTH   (28),
        .NUM_BLOCKS   (256),
        .READ_LATENCY (4),
        .INIT_FILE    ("")
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inst_read     (inst_read),
        .inst_address  (inst_address),
        .inst_readdata (inst_readdata),
        .inst_busywait (inst_busywait)
`ifdef IMEM_PROG_EN
        ,
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .prog_busy     (prog_busy)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int blk, input logic [127:0] val);
        for (int k = 0; k < 4; k++) begin
            dut.mem_words[blk*4 + k] = val[k*32 +: 32];
        end
    endtask

    // Issue a request from IDLE and count busy cycles until the RESP cycle.
    // Returns the block seen in RESP. Leaves the bench at posedge+1 of the following cycle.
    task automatic fetch(input logic [27:0] addr, input logic [27:0] alt, input bit do_switch,
                         input bit keep_read, input logic [127:0] hold_exp,
                         output logic [127:0] data, output int busy_cnt);
        bit done;
        done         = 1'b0;
        inst_read    = 1'b1;
        inst_address = addr;
        busy_cnt     = 0;
        data         = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (inst_busywait) begin
                busy_cnt++;
                chk("hold_during_busy", inst_readdata, hold_exp);
                if (do_switch && busy_cnt == 2) inst_address = alt;
                tick();
            end else begin
                data = inst_readdata;
                done = 1'b1;
            end
        end
        if (!keep_read) inst_read = 1'b0;
        tick();
    endtask

    initial begin
        logic [127:0] d;
        int           n;
        bit           got;

        preload(0, B0);
        preload(2, B2);
        preload(3, B3);
        preload(5, B5);
        preload(7, B7);
        preload(255, B255);

        // Reset with no request
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busywait", 128'(inst_busywait), 128'd0);
        chk("reset_readdata", inst_readdata, 128'h0);
        chk("reset_state", 128'(dut.state_reg), 128'(IDLE));
        tick();
        reset = 1'b1;
        tick();

        // Basic fetch of block 3
        fetch(28'd3, 28'd0, 1'b0, 1'b0, 128'h0, d, n);
        chk("basic_busy_cycles", 128'(n), 128'd5);
        chk("basic_data", d, B3);
        chk("basic_word0", 128'(d[31:0]), 128'h00000013);
        chk("basic_word3", 128'(d[127:96]), 128'h0000006F);
        @(negedge clock);
        chk("idle_hold_data", inst_readdata, B3);
        chk("idle_busywait", 128'(inst_busywait), 128'd0);
        tick();

        // Address switched to 7 during WAIT; block 3 is still returned
        fetch(28'd3, 28'd7, 1'b1, 1'b0, B3, d, n);
        chk("switch_busy_cycles", 128'(n), 128'd5);
        chk("switch_data", d, B3);

        // Back-to-back: read held across RESP, second request for block 5
        fetch(28'd3, 28'd0, 1'b0, 1'b1, B3, d, n);
        chk("b2b_first_cycles", 128'(n), 128'd5);
        chk("b2b_first_data", d, B3);
        fetch(28'd5, 28'd0, 1'b0, 1'b0, B3, d, n);
        chk("b2b_second_cycles", 128'(n), 128'd5);
        chk("b2b_second_data", d, B5);

        // Reset two cycles into WAIT
        inst_read    = 1'b1;
        inst_address = 28'd7;
        tick();
        tick();
        reset     = 1'b0;
        inst_read = 1'b0;
        #1;
        chk("midwait_rst_busywait", 128'(inst_busywait), 128'd0);
        chk("midwait_rst_readdata", inst_readdata, 128'h0);
        chk("midwait_rst_state", 128'(dut.state_reg), 128'(IDLE));
        tick();
        reset = 1'b1;
        tick();
        fetch(28'd7, 28'd0, 1'b0, 1'b0, 128'h0, d, n);
        chk("after_rst_cycles", 128'(n), 128'd5);
        chk("after_rst_data", d, B7);

        // Range boundaries
        fetch(28'd255, 28'd0, 1'b0, 1'b0, B7, d, n);
        chk("last_block_data", d, B255);
        fetch(28'd256, 28'd0, 1'b0, 1'b0, B255, d, n);
        chk("oor_256_cycles", 128'(n), 128'd5);
        chk("oor_256_data", d, 128'h0);
        fetch(28'd0, 28'd0, 1'b0, 1'b0, 128'h0, d, n);
        chk("block0_data", d, B0);
        fetch(28'h8000003, 28'd0, 1'b0, 1'b0, B0, d, n);
        chk("oor_high_data", d, 128'h0);

`ifdef IMEM_PROG_EN
        // Program a word while idle
        prog_we    = 1'b1;
        prog_addr  = 32'h24;
        prog_wdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("prog_idle_busy", 128'(prog_busy), 128'd0);
        tick();
        prog_we = 1'b0;
        fetch(28'd2, 28'd0, 1'b0, 1'b0, 128'h0, d, n);
        chk("prog_fetch_data", d, B2_P);

        // Writes with inst_read high and during WAIT are dropped
        inst_read    = 1'b1;
        inst_address = 28'd2;
        prog_we      = 1'b1;
        prog_addr    = 32'h20;
        prog_wdata   = 32'h12345678;
        @(negedge clock);
        chk("prog_busy_read", 128'(prog_busy), 128'd1);
        tick();
        @(negedge clock);
        chk("prog_busy_wait", 128'(prog_busy), 128'd1);
        tick();
        prog_we = 1'b0;
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (!inst_busywait) begin
                got = 1'b1;
                d   = inst_readdata;
            end else begin
                tick();
            end
        end
        chk("prog_wait_done", 128'(got), 128'd1);
        chk("prog_dropped_data", d, B2_P);
        inst_read = 1'b0;
        tick();

        // Out-of-range write must not alias onto block 0
        prog_we    = 1'b1;
        prog_addr  = 32'h1000;
        prog_wdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("prog_oor_busy", 128'(prog_busy), 128'd0);
        tick();
        prog_we = 1'b0;
        fetch(28'd0, 28'd0, 1'b0, 1'b0, B2_P, d, n);
        chk("prog_oor_block0", d, B0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Guard against a hung handshake.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
